// File: rtl/n_term_loopback_bist.sv
// rtl/n_term_loopback_bist.sv - loopback BIST sequencer for the north termination tile
// Drives 106 vectors northbound and checks the per-group bit-reversed southbound return.
module n_term_loopback_bist #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [51:0] tx_wires,
  input  logic [51:0] rx_wires,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  err_count,
  output logic [6:0]  first_err_vec,
  output logic [5:0]  first_err_bit
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [6:0] LAST_VEC    = 7'd105;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  function automatic logic [51:0] vector_of(input logic [6:0] v);
    logic [51:0] x;
    if (v < 7'd52)       x = 52'd1 << v;
    else if (v < 7'd104) x = ~(52'd1 << (v - 7'd52));
    else if (v == 7'd104) x = 52'hA_AAAA_AAAA_AAAA;
    else                 x = 52'h5_5555_5555_5555;
    return x;
  endfunction

  function automatic logic [51:0] expected_of(input logic [51:0] t);
    logic [51:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[i] = t[3-i];
    for (int i = 0; i < 8; i++) begin
      e[4+i]  = t[11-i];
      e[12+i] = t[19-i];
    end
    for (int i = 0; i < 16; i++) begin
      e[20+i] = t[35-i];
      e[36+i] = t[51-i];
    end
    return e;
  endfunction

  function automatic logic [5:0] lowest_set(input logic [51:0] x);
    logic [5:0] r;
    r = '0;
    for (int i = 51; i >= 0; i--) if (x[i]) r = 6'(i);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [51:0] tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [6:0]  err_q, err_d;
  logic [6:0]  fev_q, fev_d;
  logic [5:0]  feb_q, feb_d;
  logic [51:0] diff;
  logic        mismatch;

  // tx_q holds vector(vec_q) throughout CHECK, so it doubles as the compare reference.
  assign diff     = rx_wires ^ expected_of(tx_q);
  assign mismatch = |diff;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    feb_d   = feb_q;
    if ((state_q == SETTLE || state_q == CHECK) && abort) begin
      state_d = IDLE;
      tx_d    = '0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d   = '0;
          busy_d = 1'b0;
          if (start) begin
            state_d = SETTLE;
            vec_d   = '0;
            cnt_d   = '0;
            tx_d    = vector_of(7'd0);
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = '0;
            fev_d   = '0;
            feb_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_d = err_q + 7'd1;
            if (err_q == 7'd0) begin
              fev_d = vec_q;
              feb_d = lowest_set(diff);
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            tx_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_q == 7'd0) && !mismatch;
          end else begin
            state_d = SETTLE;
            vec_d   = vec_q + 7'd1;
            tx_d    = vector_of(vec_q + 7'd1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= '0;
      feb_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      feb_q   <= feb_d;
    end
  end

  assign tx_wires      = tx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = fev_q;
  assign first_err_bit = feb_q;

endmodule

// File: tb/tb_n_term_loopback_bist.sv
// tb/tb_n_term_loopback_bist.sv - randomized self-checking bench against a run-level reference model
module tb_n_term_loopback_bist;
  localparam int S = 2;
  localparam int L = 106 * (S + 1);

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [51:0] tx_wires, rx_wires;
  logic        busy, done, pass;
  logic [6:0]  err_count, first_err_vec;
  logic [5:0]  first_err_bit;

  logic        start1 = 1'b0;
  logic        abort1 = 1'b0;
  logic [51:0] tx1, rx1;
  logic        busy1, done1, pass1;
  logic [6:0]  err1, fev1;
  logic [5:0]  feb1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int mode = 0, fbit = 0, fval = 0, vb1 = 0, vb2 = 0;
  bit run_valid = 1'b0;
  bit stop_valid = 1'b0;
  int e0 = 0, stop = 0;
  bit m_bad [0:105];
  int m_lbit [0:105];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [51:0] vec_of(input int v);
    logic [51:0] x;
    x = '0;
    if (v < 52) x[v] = 1'b1;
    else if (v < 104) begin
      x = '1;
      x[v-52] = 1'b0;
    end else begin
      for (int i = 0; i < 52; i++) x[i] = (v == 104) ? (i % 2 == 1) : (i % 2 == 0);
    end
    return x;
  endfunction

  function automatic logic [51:0] rev_map(input logic [51:0] x);
    int off [0:4] = '{0, 4, 12, 20, 36};
    int wid [0:4] = '{4, 8, 8, 16, 16};
    logic [51:0] e;
    e = '0;
    for (int g = 0; g < 5; g++)
      for (int i = 0; i < wid[g]; i++) e[off[g]+i] = x[off[g]+wid[g]-1-i];
    return e;
  endfunction

  // Tile under test: 0 ideal, 1 stuck-at on one rx bit, 2 unreversed, 3 bit flip on two chosen vectors.
  function automatic logic [51:0] tile(input logic [51:0] x, input int md, input int fb,
                                       input int fv, input int b1, input int b2);
    logic [51:0] y;
    y = rev_map(x);
    case (md)
      1: y[fb] = fv[0];
      2: y = x;
      3: if (x == vec_of(b1) || x == vec_of(b2)) y[fb] = ~y[fb];
      default: ;
    endcase
    return y;
  endfunction

  assign rx_wires = tile(tx_wires, mode, fbit, fval, vb1, vb2);
  always @(posedge CLK) rx1 <= rev_map(tx1);

  n_term_loopback_bist dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .tx_wires(tx_wires), .rx_wires(rx_wires), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec), .first_err_bit(first_err_bit)
  );

  n_term_loopback_bist #(.SETTLE_CYCLES(1)) dut1 (
    .CLK(CLK), .reset(reset), .start(start1), .abort(abort1),
    .tx_wires(tx1), .rx_wires(rx1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_vec(fev1), .first_err_bit(feb1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic build_model();
    logic [51:0] d;
    bit found;
    for (int v = 0; v < 106; v++) begin
      d = tile(vec_of(v), mode, fbit, fval, vb1, vb2) ^ rev_map(vec_of(v));
      m_bad[v] = (d != '0);
      m_lbit[v] = 0;
      found = 1'b0;
      for (int i = 0; i < 52; i++) if (d[i] && !found) begin
        m_lbit[v] = i;
        found = 1'b1;
      end
    end
  endtask

  function automatic int mcount(input int k);
    int c;
    c = 0;
    for (int v = 0; v < k; v++) if (m_bad[v]) c++;
    return c;
  endfunction

  function automatic int mfirst(input int k);
    for (int v = 0; v < k; v++) if (m_bad[v]) return v;
    return -1;
  endfunction

  // Expected outputs after edge n, derived from the run's start/stop edges and checks completed so far.
  task automatic check_cycle(input int n);
    logic [51:0] etx;
    logic eb, ed, ep;
    int k, t, f;
    etx = '0; eb = 1'b0; ed = 1'b0; ep = 1'b0; k = 0;
    if (run_valid) begin
      t = n - e0;
      if (stop_valid && n >= stop) k = (stop - 1 - e0) / (S + 1);
      else if (t < L) begin
        etx = vec_of(t / (S + 1));
        eb = 1'b1;
        k = t / (S + 1);
      end else begin
        ed = (t == L);
        ep = (mcount(106) == 0);
        k = 106;
      end
    end
    f = mfirst(k);
    chk("tx_wires", 64'(tx_wires), 64'(etx));
    chk("busy", 64'(busy), 64'(eb));
    chk("done", 64'(done), 64'(ed));
    chk("pass", 64'(pass), 64'(ep));
    chk("err_count", 64'(err_count), 64'(mcount(k)));
    chk("first_err_vec", 64'(first_err_vec), (f < 0) ? 64'd0 : 64'(f));
    chk("first_err_bit", 64'(first_err_bit), (f < 0) ? 64'd0 : 64'(m_lbit[f]));
  endtask

  always @(posedge CLK) begin
    #1;
    if (!reset) check_cycle(cyc);
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic begin_run();
    @(negedge CLK);
    build_model();
    start = 1'b1;
    e0 = cyc + 1;
    run_valid = 1'b1;
    stop_valid = 1'b0;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic do_abort(input int at);
    wait_cyc(at - 1);
    abort = 1'b1;
    stop = at;
    stop_valid = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_tx_zero", 64'(tx_wires), 64'd0);
    chk("abort_pass_zero", 64'(pass), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx"}, 64'(tx_wires), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_err"}, 64'(err_count), 64'd0);
    chk({tag, "_fev"}, 64'(first_err_vec), 64'd0);
    chk({tag, "_feb"}, 64'(first_err_bit), 64'd0);
  endtask

  initial begin
    int at;
    int e01;
    int waited;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    reset = 1'b0;

    mode = 1; fbit = 20; fval = 0;
    build_model();
    chk("model_stuck20_count", 64'(mcount(106)), 64'd53);
    chk("model_stuck20_vec", 64'(mfirst(106)), 64'd35);
    chk("model_stuck20_bit", 64'(m_lbit[35]), 64'd20);
    mode = 2;
    build_model();
    chk("model_identity_count", 64'(mcount(106)), 64'd106);
    chk("model_identity_vec", 64'(mfirst(106)), 64'd0);
    mode = 0;
    build_model();
    chk("model_ideal_count", 64'(mcount(106)), 64'd0);

    begin_run();
    wait_cyc(e0 + 50);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_cyc(e0 + L);
    chk("ideal_done_at_318", 64'(done), 64'd1);
    chk("ideal_pass", 64'(pass), 64'd1);
    wait_cyc(e0 + L + 2);

    mode = 1; fbit = 20; fval = 0;
    begin_run();
    wait_cyc(e0 + L + 2);
    chk("stuck20_err", 64'(err_count), 64'd53);
    chk("stuck20_fev", 64'(first_err_vec), 64'd35);
    chk("stuck20_feb", 64'(first_err_bit), 64'd20);

    mode = 2;
    begin_run();
    wait_cyc(e0 + L + 2);
    chk("identity_err", 64'(err_count), 64'd106);
    chk("identity_pass", 64'(pass), 64'd0);

    mode = 0;
    begin_run();
    do_abort(e0 + 33);
    wait_cyc(e0 + L + 3);
    begin_run();
    wait_cyc(e0 + L + 2);
    chk("after_abort_pass", 64'(pass), 64'd1);

    begin_run();
    wait_cyc(e0 + 100);
    #2 reset = 1'b1;
    run_valid = 1'b0;
    #1 check_all_zero("midrun_reset");
    @(negedge CLK);
    reset = 1'b0;
    wait_cyc(e0 + L + 3);

    for (int r = 0; r < 8; r++) begin
      mode = int'($urandom_range(0, 3));
      fbit = int'($urandom_range(0, 51));
      fval = int'($urandom_range(0, 1));
      vb1 = int'($urandom_range(0, 105));
      vb2 = int'($urandom_range(0, 105));
      begin_run();
      if (mode == 0 && $urandom_range(0, 2) == 0) begin
        at = e0 + int'($urandom_range(1, L));
        do_abort(at);
        wait_cyc(at + 1);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          wait_cyc(e0 + int'($urandom_range(1, L - 1)));
          start = 1'b1;
          @(negedge CLK);
          start = 1'b0;
        end
        wait_cyc(e0 + L + 2);
      end
    end

    @(negedge CLK);
    start1 = 1'b1;
    e01 = cyc + 1;
    @(negedge CLK);
    start1 = 1'b0;
    waited = 0;
    while (!done1 && waited < 400) begin
      @(negedge CLK);
      waited++;
    end
    chk("s1_done_edge", 64'(cyc - e01), 64'd212);
    chk("s1_pass", 64'(pass1), 64'd1);
    chk("s1_err", 64'(err1), 64'd0);
    chk("s1_busy_low", 64'(busy1), 64'd0);
    chk("s1_fev", 64'(fev1), 64'd0);
    chk("s1_feb", 64'(feb1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n_term_loopback_bist.md
# n_term_loopback_bist

Built-in self-test sequencer for the north termination tile of the DSP column. The tile loops every northbound wire back southbound with a fixed per-group bit reversal. This block drives test vectors onto the tile's northbound inputs, waits a programmable settle time, and compares the southbound outputs against the expected reversed mapping. It sits beside the tile column in the fabric top and reports pass/fail plus first-failure diagnostics to the configuration/status logic.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before comparison; legal range 1..15.
- CLK  in  1  fabric clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state below.
- start  in  1  begin a test run; sampled only in IDLE.
- abort  in  1  synchronous; terminates a run and returns to IDLE.
- tx_wires  out  52  drive onto northbound inputs; packed [3:0]=N1END, [11:4]=N2MID, [19:12]=N2END, [35:20]=N4END, [51:36]=NN4END (index order within each group).
- rx_wires  in  52  southbound outputs, same packing: [3:0]=S1BEG, [11:4]=S2BEG, [19:12]=S2BEGb, [35:20]=S4BEG, [51:36]=SS4BEG.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  one-cycle pulse at run completion (not on abort).
- pass  out  1  high when the last completed run had zero errors.
- err_count  out  7  number of failing vectors in the current or last run.
- first_err_vec  out  7  index of the first failing vector.
- first_err_bit  out  6  lowest mismatching rx bit in that vector.

## Operation
- Expected response: for a group of width W at offset O, exp[O+i] = tx[O+W-1-i]. Groups: (O,W) = (0,4), (4,8), (12,8), (20,16), (36,16).
- Vector sequence, 106 vectors, index v:
  - v=0..51: walking one, bit v set.
  - v=52..103: walking zero, bit v-52 clear.
  - v=104: checker with odd bits set (52'hA_AAAA_AAAA_AAAA).
  - v=105: checker with even bits set (52'h5_5555_5555_5555).
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE: tx_wires=0. start=1 → clear err_count, first_err_*, pass; load v=0; go to SETTLE.
  - SETTLE: hold tx_wires=vector(v) for SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK: tx_wires stays at vector(v). Compare rx_wires against exp(v).
    - On mismatch: err_count += 1. If this is the first error of the run, capture first_err_vec=v and first_err_bit=lowest index of (rx^exp).
    - If v=105 → DONE; otherwise v+1 → SETTLE.
  - DONE: done=1, pass=(err_count==0 including this final CHECK), tx_wires=0; next state IDLE.
- abort=1 in SETTLE or CHECK: next state IDLE, tx_wires=0, pass=0, no done pulse. Diagnostics keep their partial values. abort is ignored in IDLE and DONE.
- start outside IDLE is ignored (no queuing).
- err_count max is 106, so it never wraps.
- Reset values: state IDLE, tx_wires=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_bit=0.
- reset mid-run: the run is dropped immediately and no done pulse is produced.

## Timing
- Edge E0 samples start. tx_wires=vector(0) is valid from E0 through the end of vector 0.
- Each vector occupies SETTLE_CYCLES+1 cycles. rx_wires is sampled at the edge that ends the CHECK cycle.
- done is high for exactly one cycle, beginning at edge E0 + 106·(SETTLE_CYCLES+1). For the default SETTLE_CYCLES=2 this is E0+318.
- busy is high from E0 until that edge. pass and the diagnostics become stable at the same edge and hold until the next accepted start.
- All outputs are registered; there is no combinational path from rx_wires or start to any output.

## Test plan
- Ideal loopback model (exp mapping), start pulse → done at E0+318, pass=1, err_count=0, first_err_vec=0, first_err_bit=0.
- rx bit 20 (S4BEG0) stuck at 0 → err_count=53 (v=35, v=52..103 except v=87, and v=104), first_err_vec=35, first_err_bit=20, pass=0.
- Identity (unreversed) loopback, rx=tx → err_count=106, first_err_vec=0, first_err_bit=0, pass=0.
- abort asserted during vector 10 CHECK → IDLE on next edge, tx_wires=0, no done pulse, pass=0. A following start runs the full sequence cleanly, pass=1.
- start re-asserted while busy → ignored, done still at E0+318. reset asserted at cycle 100 → all outputs at reset values immediately (asynchronous), no done pulse.
- SETTLE_CYCLES=1 with a model delaying rx by 1 cycle → pass=1, done at E0+212. Same model with SETTLE_CYCLES=0 is illegal and not exercised.
